// File: rtl/servant_spi_ram_slave.sv
// Byte-addressed SPI SRAM device model serving READ (0x03) / WRITE (0x02) with auto-increment.
// Define SPI_RAM_SLAVE_STATUS_EN to add RDSR (0x05) / WRSR (0x01) and a byte/sequential mode register.
module servant_spi_ram_slave #(
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      spi_sck,
  input  logic                      spi_ss,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      busy,
  input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
  output logic [7:0]                bd_rdata
);
  localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned NSYNC     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [7:0]  CMD_RDSR  = 8'h05;
  localparam logic [7:0]  CMD_WRSR  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_RD, ST_WR, ST_IGNORE, ST_RDSR, ST_WRSR
  } state_e;

  state_e            state_q, state_d;
  logic [NSYNC-1:0]  sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic              sck_prev_q, sck_prev_d, ss_prev_q, ss_prev_d;
  logic [6:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        abyte_q, abyte_d;
  logic              wr_q, wr_d;
  logic [23:0]       addr_q, addr_d;
  logic [6:0]        out_q, out_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;
  logic [7:0]        bd_rdata_q, bd_rdata_d;
  logic [7:0]        mem_q [MEM_DEPTH];
  logic              mem_we_c;

  logic              sck_s, ss_s, mosi_s;
  logic              sck_rise_c, sck_fall_c, ss_fall_c, ss_rise_c, byte_done_c, inc_en_c;
  logic [7:0]        rx_byte_c, rd_byte_c, rd_first_c;
  logic [23:0]       addr_next_c, addr_inc_c;

`ifdef SPI_RAM_SLAVE_STATUS_EN
  logic [7:0]        mode_q, mode_d;
  assign inc_en_c = (mode_q[7:6] != 2'b00);
`else
  assign inc_en_c = 1'b1;
`endif

  assign sck_s       = sck_sync_q[NSYNC-1];
  assign ss_s        = ss_sync_q[NSYNC-1];
  assign mosi_s      = mosi_sync_q[NSYNC-1];
  assign sck_rise_c  = ~ss_s & sck_s & ~sck_prev_q;
  assign sck_fall_c  = ~ss_s & ~sck_s & sck_prev_q;
  assign ss_fall_c   = ss_prev_q & ~ss_s;
  assign ss_rise_c   = ~ss_prev_q & ss_s;
  assign rx_byte_c   = {shift_q, mosi_s};
  assign byte_done_c = sck_rise_c & (bit_cnt_q == 3'd7);
  assign addr_next_c = {addr_q[15:0], rx_byte_c};
  assign addr_inc_c  = addr_q + 24'd1;
  assign rd_byte_c   = mem_q[addr_q[MEM_ADDR_WIDTH-1:0]];
  assign rd_first_c  = mem_q[addr_next_c[MEM_ADDR_WIDTH-1:0]];

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    sck_sync_d  = {sck_sync_q[NSYNC-2:0], spi_sck};
    ss_sync_d   = {ss_sync_q[NSYNC-2:0], spi_ss};
    mosi_sync_d = {mosi_sync_q[NSYNC-2:0], spi_mosi};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    abyte_d     = abyte_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    out_d       = out_q;
    miso_d      = 1'b0;
    mem_we_c    = 1'b0;
    bd_rdata_d  = mem_q[bd_addr];
`ifdef SPI_RAM_SLAVE_STATUS_EN
    mode_d      = mode_q;
`endif

    if (sck_rise_c) begin
      shift_d   = rx_byte_c[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_c) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
          shift_d   = 7'd0;
          abyte_d   = 2'd0;
          out_d     = 7'd0;
        end
      end
      ST_CMD: begin
        if (byte_done_c) begin
          case (rx_byte_c)
            CMD_READ:  begin state_d = ST_ADDR; wr_d = 1'b0; end
            CMD_WRITE: begin state_d = ST_ADDR; wr_d = 1'b1; end
`ifdef SPI_RAM_SLAVE_STATUS_EN
            CMD_RDSR:  state_d = ST_RDSR;
            CMD_WRSR:  state_d = ST_WRSR;
`endif
            default:   state_d = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: begin
        if (byte_done_c) begin
          addr_d  = addr_next_c;
          abyte_d = abyte_q + 2'd1;
          if (abyte_q == 2'd2) begin
            state_d = wr_q ? ST_WR : ST_RD;
            if (!wr_q) out_d = rd_first_c[6:0];
          end
        end
      end
      ST_RD: begin
        // A falling edge at bit 0 starts a fresh byte from the current address.
        miso_d = miso_q;
        if (sck_fall_c) begin
          if (bit_cnt_q == 3'd0) begin
            out_d  = rd_byte_c[6:0];
            miso_d = rd_byte_c[7];
          end else begin
            out_d  = {out_q[5:0], 1'b0};
            miso_d = out_q[6];
          end
        end
        if (byte_done_c && inc_en_c) addr_d = addr_inc_c;
      end
      ST_WR: begin
        if (byte_done_c) begin
          mem_we_c = 1'b1;
          if (inc_en_c) addr_d = addr_inc_c;
        end
      end
`ifdef SPI_RAM_SLAVE_STATUS_EN
      ST_RDSR: begin
        miso_d = miso_q;
        if (sck_fall_c) begin
          if (bit_cnt_q == 3'd0) begin
            out_d  = mode_q[6:0];
            miso_d = mode_q[7];
          end else begin
            out_d  = {out_q[5:0], 1'b0};
            miso_d = out_q[6];
          end
        end
      end
      ST_WRSR: begin
        if (byte_done_c) begin
          mode_d  = rx_byte_c;
          state_d = ST_IGNORE;
        end
      end
`endif
      ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    // Deselect wins over everything except a byte completed in the same cycle.
    if (ss_rise_c) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      out_d   = 7'd0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b1;
      ss_prev_q   <= 1'b1;
      shift_q     <= 7'd0;
      bit_cnt_q   <= 3'd0;
      abyte_q     <= 2'd0;
      wr_q        <= 1'b0;
      addr_q      <= 24'd0;
      out_q       <= 7'd0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      bd_rdata_q  <= 8'd0;
`ifdef SPI_RAM_SLAVE_STATUS_EN
      mode_q      <= 8'h40;
`endif
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      abyte_q     <= abyte_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      bd_rdata_q  <= bd_rdata_d;
`ifdef SPI_RAM_SLAVE_STATUS_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clock) begin
    if (mem_we_c && !reset) mem_q[addr_q[MEM_ADDR_WIDTH-1:0]] <= rx_byte_c;
  end

  assign spi_miso = miso_q;
  assign busy     = busy_q;
  assign bd_rdata = bd_rdata_q;
endmodule
